// File: rtl/fcmp_pkg.sv
// Shared definitions for the pipelined float compare: op codes, key constants, stage payloads.
// The FCMP_NAN_EN macro, when defined, adds NaN detection and the invalid flag (see fcmp_key).
package fcmp_pkg;

    localparam logic [1:0]  FCMP_FEQ = 2'b00;
    localparam logic [1:0]  FCMP_FLT = 2'b01;
    localparam logic [1:0]  FCMP_FLE = 2'b10;
    localparam logic [31:0] KEY_ZERO = 32'h8000_0000;

    // Stage-1 payload: ordered keys plus NaN summary of both operands.
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] k1;
        logic [31:0] k2;
        logic        nan_any;
        logic        snan_any;
    } s1_t;

    // Stage-2 payload: the compare outcome.
    typedef struct packed {
        logic res;
        logic invalid;
    } s2_t;

    function automatic s2_t fcmp_eval(input s1_t s);
        s2_t r;
        r.res     = 1'b0;
        r.invalid = 1'b0;
        case (s.op)
            FCMP_FEQ: begin
                r.res     = (s.k1 == s.k2);
                r.invalid = s.snan_any;
            end
            FCMP_FLT: begin
                r.res     = (s.k1 < s.k2);
                r.invalid = s.nan_any;
            end
            FCMP_FLE: begin
                r.res     = (s.k1 <= s.k2);
                r.invalid = s.nan_any;
            end
            default: ;
        endcase
        // An unordered operand makes every relation false.
        if (s.nan_any) begin
            r.res = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fcmp_key.sv
// Combinational IEEE-754 single -> ordered unsigned key, with NaN/sNaN flags.
// Flags are only generated when FCMP_NAN_EN is defined; otherwise they are tied low.
module fcmp_key
    import fcmp_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] key,
    output logic        nan,
    output logic        snan
);

    logic [30:0] mag;
    assign mag = x[30:0];

    // Positive values sit above negatives; negative magnitudes are inverted so order flips.
    always_comb begin
        key = KEY_ZERO;
        if (mag != 31'd0) begin
            if (!x[31]) begin
                key = {1'b1, mag};
            end else begin
                key = {1'b0, ~mag};
            end
        end
    end

`ifdef FCMP_NAN_EN
    assign nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    assign snan = nan && !x[22];
`else
    assign nan  = 1'b0;
    assign snan = 1'b0;
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined FEQ/FLT/FLE unit with valid/ready on both sides and full backpressure.
// Optional NaN handling is enabled by defining FCMP_NAN_EN (effective inside fcmp_key).
module fcmp_pipe
    import fcmp_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_invalid
);

    logic [31:0] x_arr    [2];
    logic [31:0] key_arr  [2];
    logic        nan_arr  [2];
    logic        snan_arr [2];

    assign x_arr[0] = in_x1;
    assign x_arr[1] = in_x2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            fcmp_key u_key (
                .x    (x_arr[gi]),
                .key  (key_arr[gi]),
                .nan  (nan_arr[gi]),
                .snan (snan_arr[gi])
            );
        end
    endgenerate

    logic             s1_valid_reg;
    s1_t              s1_reg;
    s1_t              s1_next;
    logic [TAG_W-1:0] s1_tag_reg;

    logic             s2_valid_reg;
    s2_t              s2_next;
    logic [31:0]      out_y_reg;
    logic [TAG_W-1:0] out_tag_reg;
    logic             out_invalid_reg;

    logic s1_load;
    logic s2_load;

    // No skid buffer: input readiness looks straight through both stages to out_ready.
    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_next.op       = in_op;
        s1_next.k1       = key_arr[0];
        s1_next.k2       = key_arr[1];
        s1_next.nan_any  = nan_arr[0] || nan_arr[1];
        s1_next.snan_any = snan_arr[0] || snan_arr[1];
    end

    assign s2_next = fcmp_eval(s1_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
        end
    end

    // Stage-1 payload is qualified by s1_valid_reg, so it needs no reset.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_reg     <= s1_next;
            s1_tag_reg <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg    <= 1'b0;
            out_y_reg       <= 32'd0;
            out_tag_reg     <= '0;
            out_invalid_reg <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_y_reg       <= {31'd0, s2_next.res};
                out_tag_reg     <= s1_tag_reg;
                out_invalid_reg <= s2_next.invalid;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_y       = out_y_reg;
    assign out_tag     = out_tag_reg;
    assign out_invalid = out_invalid_reg;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed self-checking bench for fcmp_pipe: latency, ordering, stall hold, reset flush, NaN cases.
module tb_fcmp_pipe;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [31:0]      in_x1 = 32'd0;
    logic [31:0]      in_x2 = 32'd0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_invalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_x1       (in_x1),
        .in_x2       (in_x2),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_tag     (out_tag),
        .out_invalid (out_invalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with an empty pipe and out_ready=1.
    task automatic single(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic ey, input logic einv);
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_tag   = tag;
        chk({name, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, ".lat1_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({name, ".lat2_valid"}, 32'(out_valid), 32'd1);
        chk({name, ".y"}, out_y, 32'(ey));
        chk({name, ".tag"}, 32'(out_tag), 32'(tag));
        chk({name, ".invalid"}, 32'(out_invalid), 32'(einv));
        $display("op %s op=%b x1=%h x2=%h tag=%0d -> y=%0d invalid=%0d",
                 name, op, a, b, tag, out_y, out_invalid);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        y;
    } vec_t;

    vec_t        vecs [8];
    logic        q_y   [$];
    logic [4:0]  q_tag [$];

    initial begin
        int          sent;
        int          got;
        logic        held;
        logic [31:0] hy;
        logic [4:0]  ht;
        logic        ey;
        logic [4:0]  etag;
        logic        saw;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.out_y", out_y, 32'd0);
        chk("reset.out_tag", 32'(out_tag), 32'd0);
        chk("reset.out_invalid", 32'(out_invalid), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed single ops
        single("flt_1_2",    2'b01, 32'h3F800000, 32'h40000000, 5'd1, 1'b1, 1'b0);
        single("feq_p0_n0",  2'b00, 32'h00000000, 32'h80000000, 5'd2, 1'b1, 1'b0);
        single("flt_n0_p0",  2'b01, 32'h80000000, 32'h00000000, 5'd3, 1'b0, 1'b0);
        single("fle_n0_p0",  2'b10, 32'h80000000, 32'h00000000, 5'd4, 1'b1, 1'b0);
        single("fle_m2_m1",  2'b10, 32'hC0000000, 32'hBF800000, 5'd5, 1'b1, 1'b0);
        single("flt_m1_m2",  2'b01, 32'hBF800000, 32'hC0000000, 5'd6, 1'b0, 1'b0);
        single("feq_1_1",    2'b00, 32'h3F800000, 32'h3F800000, 5'd7, 1'b1, 1'b0);
        single("flt_2_1",    2'b01, 32'h40000000, 32'h3F800000, 5'd8, 1'b0, 1'b0);
        single("fle_1_1",    2'b10, 32'h3F800000, 32'h3F800000, 5'd9, 1'b1, 1'b0);
        single("rsvd_op",    2'b11, 32'h3F800000, 32'h40000000, 5'd31, 1'b0, 1'b0);
        single("flt_m1_p1",  2'b01, 32'hBF800000, 32'h3F800000, 5'd11, 1'b1, 1'b0);
`ifdef FCMP_NAN_EN
        single("flt_qnan_1", 2'b01, 32'h7FC00000, 32'h3F800000, 5'd12, 1'b0, 1'b1);
        single("feq_qnan_q", 2'b00, 32'h7FC00000, 32'h7FC00000, 5'd13, 1'b0, 1'b0);
        single("feq_snan_1", 2'b00, 32'h7F800001, 32'h3F800000, 5'd14, 1'b0, 1'b1);
        single("fle_1_qnan", 2'b10, 32'h3F800000, 32'h7FC00000, 5'd15, 1'b0, 1'b1);
`else
        single("flt_qnan_1", 2'b01, 32'h7FC00000, 32'h3F800000, 5'd12, 1'b0, 1'b0);
        single("feq_qnan_q", 2'b00, 32'h7FC00000, 32'h7FC00000, 5'd13, 1'b1, 1'b0);
        single("feq_snan_1", 2'b00, 32'h7F800001, 32'h3F800000, 5'd14, 1'b0, 1'b0);
        single("fle_1_qnan", 2'b10, 32'h3F800000, 32'h7FC00000, 5'd15, 1'b1, 1'b0);
`endif

        // Back-to-back stream of 8 with out_ready low for cycles 3..5
        vecs[0] = '{2'b01, 32'h3F800000, 32'h40000000, 1'b1};
        vecs[1] = '{2'b00, 32'h00000000, 32'h80000000, 1'b1};
        vecs[2] = '{2'b01, 32'h80000000, 32'h00000000, 1'b0};
        vecs[3] = '{2'b10, 32'hC0000000, 32'hBF800000, 1'b1};
        vecs[4] = '{2'b01, 32'hBF800000, 32'hC0000000, 1'b0};
        vecs[5] = '{2'b00, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[6] = '{2'b10, 32'h40000000, 32'h3F800000, 1'b0};
        vecs[7] = '{2'b01, 32'hC0000000, 32'h3F800000, 1'b1};
        sent = 0;
        got  = 0;
        held = 1'b0;
        hy   = 32'd0;
        ht   = 5'd0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_op    = vecs[sent].op;
                in_x1    = vecs[sent].a;
                in_x2    = vecs[sent].b;
                in_tag   = 5'(10 + sent);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 3 && cyc <= 5) begin
                chk("stall.in_ready", 32'(in_ready), 32'd0);
            end
            if (held) begin
                chk("hold.valid", 32'(out_valid), 32'd1);
                chk("hold.y", out_y, hy);
                chk("hold.tag", 32'(out_tag), 32'(ht));
            end
            held = out_valid && !out_ready;
            hy   = out_y;
            ht   = out_tag;
            if (out_valid && out_ready) begin
                if (q_y.size() == 0) begin
                    chk("stream.unexpected_out", 32'd1, 32'd0);
                end else begin
                    ey   = q_y.pop_front();
                    etag = q_tag.pop_front();
                    chk("stream.y", out_y, 32'(ey));
                    chk("stream.tag", 32'(out_tag), 32'(etag));
                    $display("stream result %0d tag=%0d y=%0d", got, out_tag, out_y);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q_y.push_back(vecs[sent].y);
                q_tag.push_back(5'(10 + sent));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stream.count", 32'(got), 32'd8);

        // Reset with two ops in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_x1     = 32'h3F800000;
        in_x2     = 32'h40000000;
        in_tag    = 5'd20;
        @(posedge clk); #1;
        in_tag = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush.pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.out_y", out_y, 32'd0);
        chk("flush.out_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        saw       = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        chk("flush.none_emerge", 32'(saw), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        $display("flush done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
